// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: fetch sequencer states and PC constants.
// Imported by the fetch unit and by anything that needs to decode its state.
package mips_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2,
      DRAIN = 2'd3
   } fetchState_t;

   localparam logic [31:0] PC_INC           = 32'd4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_unit.sv
// Program counter plus instruction-fetch sequencer: issues req/ack fetches to instruction
// memory, holds each word for a valid/ready consumer, and accepts branch/jump redirects.
module pc_fetch_unit
   import mips_pkg::*;
#(
   parameter int                 ADDR_W   = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] pc_out,
   input  logic [ADDR_W-1:0] pc_plus4,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_target,
   input  logic              jump,
   input  logic [ADDR_W-1:0] jump_target,
   input  logic              stall,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_rdata,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [31:0]       instr,
   output logic [ADDR_W-1:0] instr_pc
);

   fetchState_t       state;
   fetchState_t       nextState;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pcNext;
   logic [ADDR_W-1:0] fetchAddr;
   logic [ADDR_W-1:0] fetchAddrNext;
   logic              validNext;
   logic              captureInstr;
   logic              redirect;
   logic [ADDR_W-1:0] rawTarget;
   logic [ADDR_W-1:0] redirectTarget;

   assign redirect       = branch_taken | jump;
   assign rawTarget      = branch_taken ? branch_target : jump_target;
   assign redirectTarget = {rawTarget[ADDR_W-1:2], 2'b00};

   assign pc_out    = pc;
   assign imem_addr = fetchAddr;
   assign imem_req  = (state == FETCH) || (state == DRAIN);

   // State register; the datapath registers follow the decisions made in the comb block.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // A redirect during an outstanding fetch cannot retract the request, so the
   // sequencer drains it (DRAIN) with the address held stable and then refetches.
   always_comb begin
      nextState     = state;
      pcNext        = pc;
      fetchAddrNext = fetchAddr;
      validNext     = instr_valid;
      captureInstr  = 1'b0;
      case (state)
         IDLE: begin
            nextState = FETCH;
            if (redirect) begin
               pcNext        = redirectTarget;
               fetchAddrNext = redirectTarget;
            end else begin
               fetchAddrNext = pc;
            end
         end
         FETCH: begin
            if (redirect) begin
               pcNext = redirectTarget;
               if (imem_ack) begin
                  fetchAddrNext = redirectTarget;
               end else begin
                  nextState = DRAIN;
               end
            end else if (imem_ack) begin
               captureInstr = 1'b1;
               validNext    = 1'b1;
               nextState    = HOLD;
            end
         end
         HOLD: begin
            if (redirect) begin
               pcNext        = redirectTarget;
               fetchAddrNext = redirectTarget;
               validNext     = 1'b0;
               nextState     = FETCH;
            end else if (instr_ready && !stall) begin
               pcNext        = pc_plus4;
               fetchAddrNext = pc_plus4;
               validNext     = 1'b0;
               nextState     = FETCH;
            end
         end
         DRAIN: begin
            if (redirect) begin
               pcNext = redirectTarget;
            end
            if (imem_ack) begin
               fetchAddrNext = redirect ? redirectTarget : pc;
               nextState     = FETCH;
            end
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // PC, fetch address and the held instruction slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc          <= RESET_PC;
         fetchAddr   <= RESET_PC;
         instr_valid <= 1'b0;
         instr       <= 32'd0;
         instr_pc    <= '0;
      end else begin
         pc          <= pcNext;
         fetchAddr   <= fetchAddrNext;
         instr_valid <= validNext;
         if (captureInstr) begin
            instr    <= imem_rdata;
            instr_pc <= fetchAddr;
         end
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: a transaction-level fetch model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_pc_fetch_unit;
   import mips_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        rstWrap;
   logic [31:0] pcOut, pcPlus4;
   logic        branchTaken, jumpIn, stallIn, instrReady;
   logic [31:0] branchTarget, jumpTarget;
   logic        imemReq, imemAck;
   logic [31:0] imemAddr, imemRdata;
   logic        instrValid;
   logic [31:0] instrOut, instrPc;

   logic [31:0] wrapPcOut, wrapPcPlus4, wrapImemAddr, wrapInstr, wrapInstrPc;
   logic        wrapImemReq, wrapInstrValid;

   int checks   = 0;
   int failures = 0;
   bit compareEn = 0;
   bit autoMem   = 1;
   int ackLatency = 1;
   int waitCnt    = 0;

   // Transaction-level model state.
   logic [31:0] mPc, mReqAddr, mInstr, mInstrPc;
   bit          mIdle, mReq, mDiscard, mValid;

   assign pcPlus4     = pcOut + PC_INC;
   assign wrapPcPlus4 = wrapPcOut + PC_INC;

   always #5 clk = ~clk;

   pc_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst(rst), .pc_out(pcOut), .pc_plus4(pcPlus4),
      .branch_taken(branchTaken), .branch_target(branchTarget),
      .jump(jumpIn), .jump_target(jumpTarget), .stall(stallIn),
      .imem_req(imemReq), .imem_addr(imemAddr), .imem_ack(imemAck), .imem_rdata(imemRdata),
      .instr_valid(instrValid), .instr_ready(instrReady), .instr(instrOut), .instr_pc(instrPc)
   );

   pc_fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dutWrap (
      .clk(clk), .rst(rstWrap), .pc_out(wrapPcOut), .pc_plus4(wrapPcPlus4),
      .branch_taken(branchTaken), .branch_target(branchTarget),
      .jump(jumpIn), .jump_target(jumpTarget), .stall(stallIn),
      .imem_req(wrapImemReq), .imem_addr(wrapImemAddr), .imem_ack(imemAck), .imem_rdata(imemRdata),
      .instr_valid(wrapInstrValid), .instr_ready(instrReady), .instr(wrapInstr), .instr_pc(wrapInstrPc)
   );

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return {~a[15:0], a[15:0]};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic timeoutFail(input string name);
      checks++;
      failures++;
      $display("[TB] FAIL %s timeout waiting for instr_valid at %0t", name, $time);
   endtask

   task automatic applyStimulus(input logic bt, input logic [31:0] btgt, input logic j,
                                input logic [31:0] jtgt, input logic stl, input logic rdy);
      branchTaken  = bt;
      branchTarget = btgt;
      jumpIn       = j;
      jumpTarget   = jtgt;
      stallIn      = stl;
      instrReady   = rdy;
   endtask

   task automatic waitValid(input string name, input bit useWrap);
      for (int i = 0; i < 20; i++) begin
         if (useWrap ? wrapInstrValid : instrValid) return;
         @(negedge clk);
      end
      timeoutFail(name);
   endtask

   // Memory responder: acks after ackLatency cycles of a continuous request.
   always begin
      @(negedge clk);
      #1;
      if (!autoMem) begin
         waitCnt = 0;
      end else if (imemReq) begin
         if (waitCnt >= ackLatency) begin
            imemAck   = 1'b1;
            imemRdata = memWord(imemAddr);
            waitCnt   = 0;
         end else begin
            imemAck = 1'b0;
            waitCnt++;
         end
      end else begin
         imemAck = 1'b0;
         waitCnt = 0;
      end
   end

   // Model: one outstanding fetch at a time, which a redirect marks as doomed.
   always @(posedge clk or posedge rst) begin
      logic        redir;
      logic [31:0] tgt;
      if (rst) begin
         mPc = 32'h0; mReqAddr = 32'h0; mInstr = 32'h0; mInstrPc = 32'h0;
         mIdle = 1; mReq = 0; mDiscard = 0; mValid = 0;
      end else begin
         redir = branchTaken | jumpIn;
         tgt   = (branchTaken ? branchTarget : jumpTarget) & 32'hFFFF_FFFC;
         if (mIdle) begin
            mIdle    = 0;
            mReq     = 1;
            mReqAddr = redir ? tgt : mPc;
            if (redir) mPc = tgt;
         end else if (mReq) begin
            if (imemAck) begin
               if (!mDiscard && !redir) begin
                  mValid = 1; mInstr = imemRdata; mInstrPc = mReqAddr; mReq = 0;
               end else begin
                  mReqAddr = redir ? tgt : mPc;
                  mDiscard = 0;
               end
            end else if (redir) begin
               mDiscard = 1;
            end
            if (redir) mPc = tgt;
         end else if (redir) begin
            mValid = 0; mPc = tgt; mReqAddr = tgt; mReq = 1;
         end else if (instrReady && !stallIn) begin
            mValid = 0; mPc = mPc + 32'd4; mReqAddr = mPc; mReq = 1;
         end
      end
   end

   // Every-cycle comparison against the model, shortly after the active edge.
   always @(posedge clk) begin
      #2;
      if (!rst && compareEn) begin
         checkOutput("model_pc_out", pcOut, mPc);
         checkOutput("model_imem_req", {31'd0, imemReq}, {31'd0, mReq});
         if (mReq) checkOutput("model_imem_addr", imemAddr, mReqAddr);
         checkOutput("model_instr_valid", {31'd0, instrValid}, {31'd0, mValid});
         checkOutput("model_instr", instrOut, mInstr);
         checkOutput("model_instr_pc", instrPc, mInstrPc);
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired at %0t", $time);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [31:0] expWords [3];
      expWords[0] = 32'hFFFF_0000;
      expWords[1] = 32'hFFFB_0004;
      expWords[2] = 32'hFFF7_0008;
      rst = 1'b1; rstWrap = 1'b1;
      imemAck = 1'b0; imemRdata = 32'h0;
      applyStimulus(0, 32'h0, 0, 32'h0, 0, 0);
      repeat (2) @(negedge clk);

      // Reset state and straight-line fetch with ready held high.
      checkOutput("reset_pc", pcOut, 32'h0);
      checkOutput("reset_req", {31'd0, imemReq}, 32'd0);
      checkOutput("reset_valid", {31'd0, instrValid}, 32'd0);
      checkOutput("reset_instr", instrOut, 32'h0);
      checkOutput("reset_instr_pc", instrPc, 32'h0);
      rst = 1'b0;
      compareEn = 1;
      applyStimulus(0, 32'h0, 0, 32'h0, 0, 1);
      for (int k = 0; k < 3; k++) begin
         waitValid("seq_valid", 0);
         checkOutput("seq_instr_pc", instrPc, 32'(k * 4));
         checkOutput("seq_instr", instrOut, expWords[k]);
         @(negedge clk);
      end

      // Reset pulse while a fetch at 0xC is outstanding, followed by a stray ack.
      autoMem = 0;
      imemAck = 1'b0;
      #1 rst = 1'b1;
      #1;
      checkOutput("midreset_pc", pcOut, 32'h0);
      checkOutput("midreset_req", {31'd0, imemReq}, 32'd0);
      checkOutput("midreset_valid", {31'd0, instrValid}, 32'd0);
      checkOutput("midreset_addr", imemAddr, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      imemAck = 1'b1;
      imemRdata = 32'hBAD0_BAD0;
      @(negedge clk);
      imemAck = 1'b0;
      autoMem = 1;
      checkOutput("stray_ack_valid", {31'd0, instrValid}, 32'd0);
      checkOutput("after_reset_req", {31'd0, imemReq}, 32'd1);
      checkOutput("after_reset_addr", imemAddr, 32'h0);

      // Hold the word at 0x10 under stall, then release.
      instrReady = 1'b0;
      for (int i = 0; i < 8; i++) begin
         waitValid("step_valid", 0);
         if (instrPc == 32'h10) break;
         instrReady = 1'b1;
         @(negedge clk);
         instrReady = 1'b0;
      end
      applyStimulus(0, 32'h0, 0, 32'h0, 1, 1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checkOutput("stall_valid", {31'd0, instrValid}, 32'd1);
         checkOutput("stall_instr", instrOut, 32'hFFEF_0010);
         checkOutput("stall_pc", pcOut, 32'h10);
      end
      stallIn = 1'b0;
      @(negedge clk);
      checkOutput("release_addr", imemAddr, 32'h14);
      checkOutput("release_req", {31'd0, imemReq}, 32'd1);

      // Branch to 0x40 while the fetch at 0x14 is still waiting for a slow ack.
      ackLatency = 3;
      applyStimulus(1, 32'h40, 0, 32'h0, 0, 0);
      @(negedge clk);
      applyStimulus(0, 32'h0, 0, 32'h0, 0, 0);
      checkOutput("drain_pc", pcOut, 32'h40);
      checkOutput("drain_addr0", imemAddr, 32'h14);
      @(negedge clk);
      checkOutput("drain_addr1", imemAddr, 32'h14);
      @(negedge clk);
      checkOutput("drain_addr2", imemAddr, 32'h14);
      @(negedge clk);
      ackLatency = 1;
      checkOutput("refetch_addr", imemAddr, 32'h40);
      checkOutput("refetch_valid", {31'd0, instrValid}, 32'd0);

      // Branch and jump together in HOLD with ready high: branch wins.
      waitValid("branch_valid", 0);
      checkOutput("branch_instr_pc", instrPc, 32'h40);
      applyStimulus(1, 32'h80, 1, 32'h200, 0, 1);
      @(negedge clk);
      applyStimulus(0, 32'h0, 0, 32'h0, 0, 0);
      checkOutput("prio_pc", pcOut, 32'h80);
      checkOutput("prio_valid", {31'd0, instrValid}, 32'd0);
      checkOutput("prio_addr", imemAddr, 32'h80);
      waitValid("prio_fetch", 0);
      checkOutput("prio_instr_pc", instrPc, 32'h80);
      checkOutput("prio_instr", instrOut, 32'hFF7F_0080);

      // Address wrap on the second instance, then an unaligned jump target.
      @(negedge clk);
      rst = 1'b1; rstWrap = 1'b1;
      instrReady = 1'b1;
      @(negedge clk);
      checkOutput("wrap_reset_pc", wrapPcOut, 32'hFFFF_FFFC);
      checkOutput("wrap_reset_req", {31'd0, wrapImemReq}, 32'd0);
      rst = 1'b0; rstWrap = 1'b0;
      waitValid("wrap_valid", 1);
      checkOutput("wrap_instr_pc", wrapInstrPc, 32'hFFFF_FFFC);
      @(negedge clk);
      instrReady = 1'b0;
      checkOutput("wrap_next_addr", wrapImemAddr, 32'h0);
      checkOutput("wrap_next_pc", wrapPcOut, 32'h0);
      waitValid("wrap_valid2", 1);
      checkOutput("wrap_instr_pc2", wrapInstrPc, 32'h0);
      applyStimulus(0, 32'h0, 1, 32'h103, 0, 0);
      @(negedge clk);
      applyStimulus(0, 32'h0, 0, 32'h0, 0, 0);
      checkOutput("jump_wrap_addr", wrapImemAddr, 32'h100);
      checkOutput("jump_addr", imemAddr, 32'h100);
      checkOutput("jump_pc", pcOut, 32'h100);
      waitValid("jump_valid", 0);
      checkOutput("jump_instr_pc", instrPc, 32'h100);
      @(negedge clk);

      compareEn = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
